bus_ram_slave: RTL and testbench
================================

BUS_RAM_SLAVE -- requirements
Module: bus_ram_slave

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, word-address width (memory depth 2^ADDR_WIDTH 32-bit words).
REQ-003 SHALL have parameter LATENCY, default 1, wait cycles inserted before ack (legal 0..15).
REQ-004 SHALL have ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous active-low reset.
- i_bus_en  in  1  request valid, held by initiator until ack.
- i_wr_en  in  1  1 = write, 0 = read.
- i_wr_data  in  32  write data.
- i_addr  in  32  byte address.
- i_byte_en  in  4  byte lane write enables, bit k = bits 8k+7:8k.
- i_atomic  in  1  atomic access (reserve on read, conditional on write).
- i_id  in  1  initiator id from upstream arbiter.
- o_ack  out  1  single-cycle completion strobe.
- o_rd_data  out  32  read data / store-conditional status, valid while o_ack=1.

Function
REQ-005 SHALL implement FSM states IDLE, WAIT, ACK; o_ack = 1 only in ACK.
REQ-006 IDLE: i_bus_en=1 at a clock edge SHALL latch wr_en, wr_data, word index i_addr[ADDR_WIDTH+1:2], byte_en, atomic, id; go to WAIT if LATENCY>0, else ACK.
REQ-007 WAIT SHALL count LATENCY cycles, then go to ACK; o_ack asserts exactly LATENCY+1 cycles after the edge that sampled the request.
REQ-008 ACK SHALL last one cycle, then return to IDLE unconditionally; back-to-back requests therefore see at least one IDLE cycle between acks.
REQ-009 i_bus_en=0 during WAIT SHALL abort: return to IDLE next edge, no memory write, no reservation change, no ack.
REQ-010 i_addr[1:0] and i_addr[31:ADDR_WIDTH+2] SHALL be ignored (address wraps modulo depth).
REQ-011 Read: o_rd_data SHALL equal the full addressed word during ACK, independent of byte_en.
REQ-012 Write SHALL commit at the ACK->IDLE edge, updating only lanes with byte_en bit set; byte_en=0 completes with ack and no change; o_rd_data = 0 for non-atomic writes.
REQ-013 Outside ACK, o_rd_data SHALL be 0.
REQ-014 Request inputs changing after latch SHALL not affect the transaction in flight.

Reset
REQ-015 Reset assertion SHALL immediately force state IDLE, o_ack=0, o_rd_data=0, wait counter 0, reservation invalid.
REQ-016 Reset mid-transaction SHALL drop the transaction with no write and no ack; memory contents are not reset.

Configuration
REQ-017 Macro BUS_RAM_SLAVE_ATOMIC_EN SHALL compile in the reservation logic.
REQ-018 With macro: atomic read sets reservation {valid=1, id, word index}; atomic write succeeds only if valid and id and index match: commit write, o_rd_data=0; otherwise no write, o_rd_data=1; either outcome clears reservation.
REQ-019 With macro: any committed non-atomic write to the reserved index (any id) SHALL clear the reservation; a new atomic read replaces it.
REQ-020 Without macro: i_atomic and i_id SHALL be ignored, atomic accesses behave as plain reads/writes, no reservation storage.

Verification
REQ-021 LATENCY=1: write 0xDEADBEEF to 0x10, byte_en=0xF -> o_ack high exactly 2 cycles after request; then read 0x10 -> o_rd_data=0xDEADBEEF during ack.
REQ-022 Word 0x10=0xDEADBEEF, write 0x000000AA, byte_en=0x1 -> subsequent read returns 0xDEADBEAA; read 0x10+(4<<ADDR_WIDTH) returns same (wrap).
REQ-023 LATENCY=3: drop i_bus_en 1 cycle into WAIT on write of 0x12345678 -> no ack, word unchanged, FSM IDLE next cycle.
REQ-024 Macro on: id0 atomic read 0x20, id0 atomic write 0x55 -> o_rd_data=0, word=0x55; repeat atomic write 0x66 -> o_rd_data=1, word stays 0x55.
REQ-025 Macro on: id0 atomic read 0x20, id1 plain write 0x77 to 0x20, id0 atomic write 0x88 -> o_rd_data=1, word=0x77.
REQ-026 Assert i_rst low during WAIT of a write -> o_ack=0 and o_rd_data=0 immediately, word unchanged, reservation cleared.

Source files
------------

// File: rtl/bus_ram_slave.sv
// bus_ram_slave: 32-bit word RAM behind a simple request/ack bus slave.
//
// Handshake: the initiator raises i_bus_en with the request fields and holds
// it until o_ack. The slave samples the request in IDLE, waits LATENCY cycles
// in WAIT, then pulses o_ack for exactly one cycle in ACK. Dropping i_bus_en
// during WAIT aborts the request with no side effects. Writes commit on the
// ACK->IDLE edge. o_rd_data is zero whenever o_ack is low.
//
// Optional feature: define BUS_RAM_SLAVE_ATOMIC_EN to compile in a single
// load-reserved / store-conditional reservation. Without it, i_atomic and
// i_id are ignored.
//
// Debug: o_state exposes the FSM state (0 = IDLE, 1 = WAIT, 2 = ACK).
module bus_ram_slave #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bus_en,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_data,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_byte_en,
    input  logic        i_atomic,
    input  logic        i_id,
    output logic        o_ack,
    output logic [31:0] o_rd_data,
    output logic [1:0]  o_state
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    // Terminal count of the wait counter; unused when LATENCY is 0.
    localparam logic [3:0] LAST_WAIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    wr_en_q, wr_en_d;
    logic [31:0]             wr_data_q, wr_data_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [3:0]              be_q, be_d;
    logic                    req_take;
    logic                    write_ok;
    logic                    sc_fail;
    logic                    mem_we;
    logic [31:0]             mem_wdata;
    logic [31:0]             mem_q [DEPTH];

    // Byte-offset bits and address bits above the RAM depth are ignored.
    logic unused_addr;
    assign unused_addr = ^{i_addr[31:ADDR_WIDTH+2], i_addr[1:0]};

    assign req_take = (state_q == ST_IDLE) && i_bus_en;

    // FSM state and wait counter registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE -> (WAIT) -> ACK -> IDLE, abort when bus_en drops in WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_bus_en) begin
                    cnt_d   = '0;
                    state_d = (LATENCY == 0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!i_bus_en) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == LAST_WAIT) begin
                    cnt_d   = '0;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the request fields when a request is accepted in IDLE.
    always_comb begin
        wr_en_d   = wr_en_q;
        wr_data_d = wr_data_q;
        idx_d     = idx_q;
        be_d      = be_q;
        if (req_take) begin
            wr_en_d   = i_wr_en;
            wr_data_d = i_wr_data;
            idx_d     = i_addr[ADDR_WIDTH+1:2];
            be_d      = i_byte_en;
        end
    end

    // Latched request registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            idx_q     <= '0;
            be_q      <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            idx_q     <= idx_d;
            be_q      <= be_d;
        end
    end

`ifdef BUS_RAM_SLAVE_ATOMIC_EN
    logic                  atomic_q, atomic_d;
    logic                  id_q, id_d;
    logic                  res_valid_q, res_valid_d;
    logic                  res_id_q, res_id_d;
    logic [ADDR_WIDTH-1:0] res_idx_q, res_idx_d;
    logic                  res_match;

    // Atomic qualifiers travel with the rest of the request; reservation
    // changes are applied as the ACK cycle retires.
    always_comb begin
        atomic_d    = atomic_q;
        id_d        = id_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_idx_d   = res_idx_q;
        res_match   = res_valid_q && (res_id_q == id_q) && (res_idx_q == idx_q);
        if (req_take) begin
            atomic_d = i_atomic;
            id_d     = i_id;
        end
        if (state_q == ST_ACK) begin
            if (!wr_en_q && atomic_q) begin
                res_valid_d = 1'b1;
                res_id_d    = id_q;
                res_idx_d   = idx_q;
            end else if (wr_en_q && atomic_q) begin
                res_valid_d = 1'b0;
            end else if (wr_en_q && (res_idx_q == idx_q)) begin
                res_valid_d = 1'b0;
            end
        end
    end

    // Atomic qualifier and reservation registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            atomic_q    <= 1'b0;
            id_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_idx_q   <= '0;
        end else begin
            atomic_q    <= atomic_d;
            id_q        <= id_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_idx_q   <= res_idx_d;
        end
    end

    assign write_ok = !atomic_q || res_match;
    assign sc_fail  = atomic_q && !res_match;
`else
    logic unused_atomic;
    assign unused_atomic = i_atomic ^ i_id;
    assign write_ok      = 1'b1;
    assign sc_fail       = 1'b0;
`endif

    // Byte-lane merge of the write data into the addressed word.
    always_comb begin
        mem_we    = (state_q == ST_ACK) && wr_en_q && write_ok;
        mem_wdata = mem_q[idx_q];
        for (int k = 0; k < 4; k++) begin
            if (be_q[k]) begin
                mem_wdata[8*k +: 8] = wr_data_q[8*k +: 8];
            end
        end
    end

    // RAM storage; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= mem_wdata;
        end
    end

    // Outputs: ack and response data only in ACK.
    always_comb begin
        o_ack     = (state_q == ST_ACK);
        o_rd_data = '0;
        o_state   = state_q;
        if (state_q == ST_ACK) begin
            if (!wr_en_q) begin
                o_rd_data = mem_q[idx_q];
            end else if (sc_fail) begin
                o_rd_data = 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_bus_ram_slave.sv
// Testbench for bus_ram_slave: directed scenarios plus random traffic,
// checked against a word-array reference model through an expected queue.
module tb_bus_ram_slave;

  localparam int AW    = 6;
  localparam int LAT   = 3;
  localparam int DEPTH = 1 << AW;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_bus_en = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [31:0] i_wr_data = '0;
  logic [31:0] i_addr = '0;
  logic [3:0]  i_byte_en = '0;
  logic        i_atomic = 1'b0;
  logic        i_id = 1'b0;
  logic        o_ack;
  logic [31:0] o_rd_data;
  logic [1:0]  o_state;

  bus_ram_slave #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_bus_en(i_bus_en), .i_wr_en(i_wr_en),
    .i_wr_data(i_wr_data), .i_addr(i_addr), .i_byte_en(i_byte_en),
    .i_atomic(i_atomic), .i_id(i_id), .o_ack(o_ack), .o_rd_data(o_rd_data),
    .o_state(o_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];

  // reference model: plain word array plus one reservation record
  logic [31:0] mem_m [DEPTH];
  bit          res_v = 1'b0;
  bit          res_id = 1'b0;
  int          res_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge i_clk) begin : monitor
    logic [31:0] e;
    int c;
    if (i_rst) begin
      if (o_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: ack with rd_data %h, required no ack (cycle %0d)", o_rd_data, cyc);
        end else begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          chk("rd_data", o_rd_data, e);
          chk("ack_cycle", cyc, c);
        end
      end else begin
        chk("rd_data_zero_outside_ack", o_rd_data, 32'd0);
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic model_txn(input bit wr, input logic [31:0] data, input logic [31:0] addr,
                           input logic [3:0] be, input bit atomic, input bit id,
                           output logic [31:0] resp);
    int idx;
    bit commit;
    idx    = int'(addr[AW+1:2]);
    commit = 1'b1;
    resp   = 32'd0;
    if (!wr) begin
      resp = mem_m[idx];
`ifdef BUS_RAM_SLAVE_ATOMIC_EN
      if (atomic) begin
        res_v   = 1'b1;
        res_id  = id;
        res_idx = idx;
      end
`endif
    end else begin
`ifdef BUS_RAM_SLAVE_ATOMIC_EN
      if (atomic) begin
        commit = res_v && (res_id == id) && (res_idx == idx);
        resp   = commit ? 32'd0 : 32'd1;
        res_v  = 1'b0;
      end else if (res_v && res_idx == idx) begin
        res_v = 1'b0;
      end
`endif
      if (commit) begin
        for (int k = 0; k < 4; k++)
          if (be[k]) mem_m[idx][8*k +: 8] = data[8*k +: 8];
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic scramble_fields();
    i_wr_en   = 1'($urandom);
    i_wr_data = $urandom;
    i_addr    = $urandom;
    i_byte_en = 4'($urandom);
    i_atomic  = 1'($urandom);
    i_id      = 1'($urandom);
  endtask

  task automatic wait_ack();
    for (int k = 0; k < 40 && !o_ack; k++) @(negedge i_clk);
    if (!o_ack) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: no ack within 40 cycles, required ack by cycle %0d", cyc);
    end
  endtask

  task automatic issue(input bit wr, input logic [31:0] data, input logic [31:0] addr,
                       input logic [3:0] be, input bit atomic, input bit id, input bit abort);
    logic [31:0] resp;
    int n;
    @(negedge i_clk);
    i_wr_en = wr; i_wr_data = data; i_addr = addr; i_byte_en = be;
    i_atomic = atomic; i_id = id; i_bus_en = 1'b1;
    n = cyc;
    if (abort) begin
      @(negedge i_clk);
      scramble_fields();
      i_bus_en = 1'b0;
      @(negedge i_clk);
      chk("abort_state_idle", {30'd0, o_state}, 32'd0);
      return;
    end
    model_txn(wr, data, addr, be, atomic, id, resp);
    exp_q.push_back(resp);
    exp_cyc_q.push_back(n + 1 + LAT);
    @(negedge i_clk);
    scramble_fields();
    i_bus_en = 1'b1;
    wait_ack();
    i_bus_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"}, {31'd0, o_ack}, 32'd0);
    chk({tag, "_rd_data"}, o_rd_data, 32'd0);
    chk({tag, "_state"}, {30'd0, o_state}, 32'd0);
  endtask

  task automatic reset_in_wait(input logic [31:0] addr, input logic [31:0] data);
    @(negedge i_clk);
    i_wr_en = 1'b1; i_wr_data = data; i_addr = addr; i_byte_en = 4'hF;
    i_atomic = 1'b0; i_id = 1'b0; i_bus_en = 1'b1;
    @(negedge i_clk);
    #2 i_rst = 1'b0;
    #1 check_reset_outputs("reset_in_wait");
    i_bus_en = 1'b0;
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    res_v = 1'b0;
  endtask

  task automatic reset_in_ack(input logic [31:0] addr, input logic [31:0] data);
    int n;
    @(negedge i_clk);
    i_wr_en = 1'b1; i_wr_data = data; i_addr = addr; i_byte_en = 4'hF;
    i_atomic = 1'b0; i_id = 1'b0; i_bus_en = 1'b1;
    n = cyc;
    exp_q.push_back(32'd0);
    exp_cyc_q.push_back(n + 1 + LAT);
    wait_ack();
    #2 i_rst = 1'b0;
    #1 check_reset_outputs("reset_in_ack");
    i_bus_en = 1'b0;
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    res_v = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] r;
    logic [AW-1:0] word;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("por");
    #2 i_rst = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      issue(1'b1, $urandom, 32'(i * 4), 4'hF, 1'b0, 1'b0, 1'b0);

    // full write, read back, byte-lane write, wrapped alias read
    issue(1'b1, 32'hDEADBEEF, 32'h10, 4'hF, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 32'h0, 32'h10, 4'h0, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 32'h000000AA, 32'h10, 4'h1, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 32'h0, 32'h10, 4'h0, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 32'h0, 32'h10 + (32'd4 << AW), 4'h5, 1'b0, 1'b0, 1'b0);
    // zero byte enables, abort mid-WAIT, then confirm word intact
    issue(1'b1, 32'h11223344, 32'h10, 4'h0, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 32'h12345678, 32'h10, 4'hF, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 32'h0, 32'h13, 4'h0, 1'b0, 1'b0, 1'b0);

    // reservation success then repeated store-conditional
    issue(1'b0, 32'h0, 32'h20, 4'hF, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 32'h55, 32'h20, 4'hF, 1'b1, 1'b0, 1'b0);
    issue(1'b0, 32'h0, 32'h20, 4'hF, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 32'h66, 32'h20, 4'hF, 1'b1, 1'b0, 1'b0);
    issue(1'b0, 32'h0, 32'h20, 4'hF, 1'b0, 1'b0, 1'b0);
    // reservation broken by another initiator's plain write
    issue(1'b0, 32'h0, 32'h20, 4'hF, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 32'h77, 32'h20, 4'hF, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 32'h88, 32'h20, 4'hF, 1'b1, 1'b0, 1'b0);
    issue(1'b0, 32'h0, 32'h20, 4'hF, 1'b0, 1'b0, 1'b0);

    // reset during WAIT of a write: reservation lost, word kept
    issue(1'b0, 32'h0, 32'h20, 4'hF, 1'b1, 1'b0, 1'b0);
    reset_in_wait(32'h20, 32'h12345678);
    issue(1'b1, 32'h99, 32'h20, 4'hF, 1'b1, 1'b0, 1'b0);
    issue(1'b0, 32'h0, 32'h20, 4'hF, 1'b0, 1'b0, 1'b0);
    // reset during ACK of a write: write dropped
    reset_in_ack(32'h08, 32'hCAFEF00D);
    issue(1'b0, 32'h0, 32'h08, 4'hF, 1'b0, 1'b0, 1'b0);

    // random traffic, biased toward a few words so reservations get reused
    for (int t = 0; t < 400; t++) begin
      r    = $urandom;
      word = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
      issue(1'($urandom), $urandom, {r[31:AW+2], word, r[1:0]}, 4'($urandom),
            1'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0));
    end

    repeat (4) @(negedge i_clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
